dvi_rx_chan_align: RTL and testbench



---
 rtl/dvi_rx_chan_align.sv | 173 +++++++++++++++++
 tb/tb_dvi_rx_chan_align.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_rx_chan_align.sv
// rtl/dvi_rx_chan_align.sv - TMDS channel word aligner (bitslip hunt) and decoder.
// Optional DVI_RX_LOCK_LOSS_CNT_EN adds o_lock_loss_cnt, a saturating count of lock losses.
module dvi_rx_chan_align #(
    parameter int CTRL_RUN_LEN = 128,
    parameter int HUNT_WINDOW  = 2048,
    parameter int SLIP_SETTLE  = 4
) (
    input  logic       i_clk,
    input  logic       i_arst,
    input  logic [9:0] i_data,
    output logic       o_bitslip,
    output logic       o_locked,
    output logic [7:0] o_data,
    output logic       o_de,
    output logic [1:0] o_c
`ifdef DVI_RX_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0] o_lock_loss_cnt
`endif
);
    localparam int RUN_W = $clog2(CTRL_RUN_LEN + 1);
    localparam int WIN_W = $clog2(HUNT_WINDOW + 1);
    localparam int GAP_W = $clog2(HUNT_WINDOW + 1);
    localparam int SET_W = $clog2(SLIP_SETTLE + 1);

    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(CTRL_RUN_LEN - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(HUNT_WINDOW - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(HUNT_WINDOW - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SLIP_SETTLE - 1);

    typedef enum logic [1:0] {
        S_HUNT,
        S_SLIP,
        S_SETTLE,
        S_LOCKED
    } state_t;

    state_t           r_state;
    logic [RUN_W-1:0] r_run_cnt;
    logic [WIN_W-1:0] r_win_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [SET_W-1:0] r_settle_cnt;
    logic             r_bitslip;
    logic             r_locked;
    logic [7:0]       r_data;
    logic             r_de;
    logic [1:0]       r_c;
    logic [7:0]       r_loss_cnt;

    logic       w_tok;
    logic [1:0] w_tok_c;
    logic [7:0] w_q;
    logic [7:0] w_x;
    logic [7:0] w_dec;
    logic       w_run_hit;
    logic       w_gap_hit;
    logic       w_lock_next;

    always_comb begin
        w_tok   = 1'b1;
        w_tok_c = 2'b00;
        case (i_data)
            10'h354: w_tok_c = 2'b00;
            10'h0AB: w_tok_c = 2'b01;
            10'h154: w_tok_c = 2'b10;
            10'h2AB: w_tok_c = 2'b11;
            default: w_tok   = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR chain; bit 0 passes straight through.
    assign w_q   = i_data[9] ? ~i_data[7:0] : i_data[7:0];
    assign w_x   = w_q ^ {w_q[6:0], 1'b0};
    assign w_dec = i_data[8] ? w_x : {~w_x[7:1], w_x[0]};

    assign w_run_hit   = w_tok && (r_run_cnt == RUN_LAST);
    assign w_gap_hit   = !w_tok && (r_gap_cnt == GAP_LAST);
    assign w_lock_next = ((r_state == S_HUNT) && w_run_hit) ||
                         ((r_state == S_LOCKED) && !w_gap_hit);

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state      <= S_HUNT;
            r_run_cnt    <= '0;
            r_win_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_settle_cnt <= '0;
            r_bitslip    <= 1'b0;
            r_locked     <= 1'b0;
            r_data       <= 8'h00;
            r_de         <= 1'b0;
            r_c          <= 2'b00;
            r_loss_cnt   <= 8'h00;
        end else begin
            r_bitslip <= 1'b0;
            r_locked  <= w_lock_next;
            // Outputs follow the next state so the lock word is decoded and loss shows zeros at once.
            if (w_lock_next) begin
                if (w_tok) begin
                    r_de   <= 1'b0;
                    r_c    <= w_tok_c;
                    r_data <= 8'h00;
                end else begin
                    r_de   <= 1'b1;
                    r_data <= w_dec;
                end
            end else begin
                r_de   <= 1'b0;
                r_c    <= 2'b00;
                r_data <= 8'h00;
            end

            case (r_state)
                S_HUNT: begin
                    if (w_run_hit) begin
                        r_state   <= S_LOCKED;
                        r_run_cnt <= '0;
                        r_win_cnt <= '0;
                        r_gap_cnt <= '0;
                    end else begin
                        r_run_cnt <= w_tok ? r_run_cnt + RUN_W'(1) : '0;
                        if (r_win_cnt == WIN_LAST) begin
                            r_state   <= S_SLIP;
                            r_bitslip <= 1'b1;
                            r_win_cnt <= '0;
                        end else begin
                            r_win_cnt <= r_win_cnt + WIN_W'(1);
                        end
                    end
                end
                S_SLIP: begin
                    r_state      <= S_SETTLE;
                    r_settle_cnt <= '0;
                end
                S_SETTLE: begin
                    if (r_settle_cnt == SET_LAST) begin
                        r_state      <= S_HUNT;
                        r_settle_cnt <= '0;
                        r_run_cnt    <= '0;
                        r_win_cnt    <= '0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SET_W'(1);
                    end
                end
                S_LOCKED: begin
                    if (w_gap_hit) begin
                        r_state   <= S_HUNT;
                        r_gap_cnt <= '0;
                        r_run_cnt <= '0;
                        r_win_cnt <= '0;
                        if (r_loss_cnt != 8'hFF) r_loss_cnt <= r_loss_cnt + 8'h01;
                    end else begin
                        r_gap_cnt <= w_tok ? '0 : r_gap_cnt + GAP_W'(1);
                    end
                end
                default: r_state <= S_HUNT;
            endcase
        end
    end

    assign o_bitslip = r_bitslip;
    assign o_locked  = r_locked;
    assign o_data    = r_data;
    assign o_de      = r_de;
    assign o_c       = r_c;
`ifdef DVI_RX_LOCK_LOSS_CNT_EN
    assign o_lock_loss_cnt = r_loss_cnt;
`else
    logic w_loss_unused;
    assign w_loss_unused = ^r_loss_cnt;
`endif

endmodule

// File: tb/tb_dvi_rx_chan_align.sv
// tb/tb_dvi_rx_chan_align.sv - bench for dvi_rx_chan_align: directed vectors plus random stream vs reference model.
module tb_dvi_rx_chan_align;
    localparam int N  = 8;
    localparam int HW = 64;
    localparam int SS = 4;

    logic       clk  = 1'b0;
    logic       arst = 1'b1;
    logic [9:0] din  = 10'h000;
    logic       o_bitslip, o_locked, o_de;
    logic [7:0] o_data;
    logic [1:0] o_c;
`ifdef DVI_RX_LOCK_LOSS_CNT_EN
    logic [7:0] o_lock_loss_cnt;
`endif

    dvi_rx_chan_align #(.CTRL_RUN_LEN(N), .HUNT_WINDOW(HW), .SLIP_SETTLE(SS)) dut (
        .i_clk(clk),
        .i_arst(arst),
        .i_data(din),
        .o_bitslip(o_bitslip),
        .o_locked(o_locked),
        .o_data(o_data),
        .o_de(o_de),
        .o_c(o_c)
`ifdef DVI_RX_LOCK_LOSS_CNT_EN
        ,
        .o_lock_loss_cnt(o_lock_loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int bs_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic int tok_val(input logic [9:0] w);
        logic [9:0] toks [4];
        toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;
        for (int i = 0; i < 4; i++) if (w == toks[i]) return i;
        return -1;
    endfunction

    function automatic int tmds_dec(input logic [9:0] w);
        int q, r, b;
        q = w[9] ? (~int'(w[7:0]) & 255) : int'(w[7:0]);
        r = q & 1;
        for (int k = 1; k < 8; k++) begin
            b = ((q >> k) & 1) ^ ((q >> (k - 1)) & 1);
            if (!w[8]) b = b ^ 1;
            r = r | (b << k);
        end
        return r;
    endfunction

    function automatic logic [9:0] rot10(input logic [9:0] w, input int k);
        int v;
        v = ((int'(w) << k) | (int'(w) >> (10 - k))) & 10'h3FF;
        return v[9:0];
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        w = 10'($urandom_range(0, 1023));
        while (tok_val(w) >= 0) w = 10'($urandom_range(0, 1023));
        return w;
    endfunction

    function automatic logic [9:0] rand_tok();
        logic [9:0] toks [4];
        toks[0] = 10'h354; toks[1] = 10'h0AB; toks[2] = 10'h154; toks[3] = 10'h2AB;
        return toks[$urandom_range(0, 3)];
    endfunction

    // Reference model: mode 0 hunting, 1 blind (slip plus settle), 2 locked.
    int m_mode = 0, m_age = 0, m_run = 0, m_gap = 0, m_left = 0, m_loss = 0, m_t = 0;
    logic       e_locked = 0, e_bs = 0, e_de = 0;
    logic [1:0] e_c = 0;
    logic [7:0] e_data = 0;

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            m_mode = 0; m_age = 0; m_run = 0; m_gap = 0; m_left = 0; m_loss = 0;
            e_locked = 0; e_bs = 0; e_de = 0; e_c = 0; e_data = 0;
        end else begin
            m_t  = tok_val(din);
            e_bs = 1'b0;
            case (m_mode)
                0: begin
                    m_run = (m_t >= 0) ? m_run + 1 : 0;
                    if (m_run == N) begin
                        m_mode = 2; m_gap = 0;
                    end else begin
                        m_age++;
                        if (m_age == HW) begin m_mode = 1; m_left = 1 + SS; e_bs = 1'b1; end
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin m_mode = 0; m_age = 0; m_run = 0; end
                end
                default: begin
                    m_gap = (m_t >= 0) ? 0 : m_gap + 1;
                    if (m_gap == HW) begin
                        m_mode = 0; m_age = 0; m_run = 0;
                        if (m_loss < 255) m_loss++;
                    end
                end
            endcase
            e_locked = (m_mode == 2);
            if (!e_locked) begin
                e_de = 0; e_c = 0; e_data = 0;
            end else if (m_t >= 0) begin
                e_de = 0; e_c = m_t[1:0]; e_data = 0;
            end else begin
                e_de = 1; e_data = tmds_dec(din)[7:0];
            end
        end
    end

    always @(negedge clk) begin
        if (!arst) begin
            chk("scoreboard{locked,bitslip,de,c,data}", {o_locked, o_bitslip, o_de, o_c, o_data},
                {e_locked, e_bs, e_de, e_c, e_data});
`ifdef DVI_RX_LOCK_LOSS_CNT_EN
            chk("scoreboard_loss_cnt", o_lock_loss_cnt, m_loss[7:0]);
`endif
            if (o_bitslip) bs_cnt++;
        end
    end

    task automatic drive(input logic [9:0] w);
        din = w;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst = 1'b1;
        din  = 10'h000;
        repeat (2) @(negedge clk);
        arst = 1'b0;
    endtask

    typedef struct {
        logic [9:0] w;
        logic       de;
        logic [1:0] c;
        logic [7:0] d;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int p[$];
        int cyc, off, lock_cyc, n;
        logic prev_bs;

        tbl[0]  = '{10'h1FF, 1'b1, 2'b00, 8'h01};
        tbl[1]  = '{10'h2AB, 1'b0, 2'b11, 8'h00};
        tbl[2]  = '{10'h100, 1'b1, 2'b11, 8'h00};
        tbl[3]  = '{10'h0AB, 1'b0, 2'b01, 8'h00};
        tbl[4]  = '{10'h0FF, 1'b1, 2'b01, 8'hFF};
        tbl[5]  = '{10'h3FF, 1'b1, 2'b01, 8'h00};
        tbl[6]  = '{10'h154, 1'b0, 2'b10, 8'h00};
        tbl[7]  = '{10'h155, 1'b1, 2'b10, 8'hFF};
        tbl[8]  = '{10'h354, 1'b0, 2'b00, 8'h00};
        tbl[9]  = '{10'h200, 1'b1, 2'b00, 8'hFF};
        tbl[10] = '{10'h0F0, 1'b1, 2'b00, 8'hEE};

        do_reset();
        chk("reset_outputs", {o_locked, o_bitslip, o_de, o_c, o_data}, 13'h0);
`ifdef DVI_RX_LOCK_LOSS_CNT_EN
        chk("reset_loss_cnt", o_lock_loss_cnt, 8'h00);
`endif

        // Aligned lock
        bs_cnt = 0;
        for (int i = 1; i <= N; i++) begin
            drive(10'h354);
            if (i == N - 1) chk("lock_not_before_8th", o_locked, 1'b0);
        end
        chk("lock_after_8th", o_locked, 1'b1);
        chk("lock_word_decode", {o_de, o_c}, 3'b000);
        chk("aligned_no_bitslip", bs_cnt, 0);

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].w);
            chk($sformatf("decode_vec%0d", i), {o_locked, o_de, o_c, o_data},
                {1'b1, tbl[i].de, tbl[i].c, tbl[i].d});
        end

        // Lock loss after HW tokenless words
        drive(10'h354);
        for (int i = 1; i <= HW; i++) begin
            drive(rand_data());
            if (i == HW - 1) chk("still_locked_63", o_locked, 1'b1);
        end
        chk("lock_lost", {o_locked, o_de, o_c, o_data}, 12'h0);
`ifdef DVI_RX_LOCK_LOSS_CNT_EN
        chk("loss_cnt_one", o_lock_loss_cnt, 8'h01);
`endif

        // Misaligned hunt: stream rotated by 3, each bitslip removes one position
        do_reset();
        off = 3; cyc = 0; lock_cyc = -1; prev_bs = 0;
        while (cyc < 400 && lock_cyc < 0) begin
            drive(rot10(10'h354, off));
            cyc++;
            if (o_bitslip && prev_bs) chk("bitslip_width", 2, 1);
            prev_bs = o_bitslip;
            if (o_bitslip) begin
                p.push_back(cyc);
                off = (off + 9) % 10;
            end
            if (o_locked) lock_cyc = cyc;
        end
        chk("misalign_locked", lock_cyc >= 0, 1'b1);
        chk("misalign_pulses", p.size(), 3);
        if (p.size() == 3) begin
            chk("first_slip_cycle", p[0], HW);
            chk("slip_period_1", p[1] - p[0], HW + 1 + SS);
            chk("slip_period_2", p[2] - p[1], HW + 1 + SS);
            chk("lock_after_last_slip", lock_cyc - p[2], 1 + SS + N);
        end

        // Lock and window expiry on the same cycle
        do_reset();
        bs_cnt = 0;
        for (int i = 0; i < HW - N; i++) drive(rand_data());
        for (int i = 1; i <= N; i++) begin
            drive(rand_tok());
            if (i == N - 1) chk("coinc_not_yet", o_locked, 1'b0);
        end
        chk("coinc_locked", o_locked, 1'b1);
        chk("coinc_no_bitslip", bs_cnt, 0);

        // Asynchronous reset while locked with a data word on the outputs
        drive(10'h0FF);
        chk("pre_reset_de", {o_de, o_data}, 9'h1FF);
        #2 arst = 1'b1;
        #1 chk("async_reset_locked", {o_locked, o_bitslip, o_de, o_c, o_data}, 13'h0);
        @(negedge clk);
        arst = 1'b0;

        // Reset pulsed mid-SETTLE: window must restart from zero
        for (int i = 1; i <= HW; i++) drive(rand_data());
        chk("slip_at_window", o_bitslip, 1'b1);
        drive(rand_data());
        drive(rand_data());
        #2 arst = 1'b1;
        #1 chk("async_reset_settle", {o_locked, o_bitslip, o_de, o_c, o_data}, 13'h0);
        @(negedge clk);
        arst = 1'b0;
        n = 0;
        while (n < 200) begin
            drive(rand_data());
            n++;
            if (o_bitslip) break;
        end
        chk("window_restart", n, HW);

        // Random bursts of tokens and data against the model
        do_reset();
        for (int b = 0; b < 40; b++) begin
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) drive(rand_tok());
            n = $urandom_range(0, 90);
            for (int i = 0; i < n; i++) drive(10'($urandom_range(0, 1023)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
